// File: rtl/transmitter_serial_if.sv
// transmitter_serial_if: write handshake and serial line of the transmitter.
// The master side issues writes and watches the line; the slave side is the transmitter.
interface transmitter_serial_if;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       txd;
  logic       tx_ready;
  logic       tx_busy;

  modport master (
    output tx_en,
    output tx_data,
    input  txd,
    input  tx_ready,
    input  tx_busy
  );

  modport slave (
    input  tx_en,
    input  tx_data,
    output txd,
    output tx_ready,
    output tx_busy
  );
endinterface

// File: rtl/transmitter_serial.sv
// transmitter_serial: 8N1 serial transmitter, DIVISOR clk cycles per bit.
// A one-byte holding buffer sits in front of the shift register, so a second
// byte can be queued while a frame is on the line and sent with no idle gap.
module transmitter_serial #(
  parameter int DIVISOR = 1
) (
  input logic                 clk,
  input logic                 rst,
  transmitter_serial_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(DIVISOR - 1);

  state_t      state;
  logic [7:0]  hold_buf;
  logic [7:0]  shift_reg;
  logic [2:0]  bit_count;
  logic [15:0] baud_count;
  logic        txd_reg;
  logic        ready_reg;
  logic        busy_reg;
  logic        baud_done;

  // The holding buffer is full exactly when ready_reg is low, so no separate
  // full flag is kept.
  assign baud_done    = (baud_count == BAUD_LAST);
  assign bus.txd      = txd_reg;
  assign bus.tx_ready = ready_reg;
  assign bus.tx_busy  = busy_reg;

  // Frame sequencer: state, counters, buffer, handshake flags and the line register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hold_buf   <= '0;
      shift_reg  <= '0;
      bit_count  <= '0;
      baud_count <= '0;
      txd_reg    <= 1'b1;
      ready_reg  <= 1'b1;
      busy_reg   <= 1'b0;
    end else begin
      // The line register is driven from the state held during the previous
      // cycle, which is what places the start bit two edges after the accept.
      case (state)
        IDLE:    txd_reg <= 1'b1;
        START:   txd_reg <= 1'b0;
        DATA:    txd_reg <= shift_reg[0];
        STOP:    txd_reg <= 1'b1;
        default: txd_reg <= 1'b1;
      endcase

      case (state)
        IDLE: begin
          baud_count <= '0;
          if (!ready_reg) begin
            state      <= START;
            shift_reg  <= hold_buf;
            ready_reg  <= 1'b1;
            busy_reg   <= 1'b1;
          end
        end
        START: begin
          if (baud_done) begin
            state      <= DATA;
            bit_count  <= '0;
            baud_count <= '0;
          end else begin
            baud_count <= baud_count + 16'd1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_count <= '0;
            shift_reg  <= {1'b0, shift_reg[7:1]};
            if (bit_count == 3'd7) begin
              state <= STOP;
            end else begin
              bit_count <= bit_count + 3'd1;
            end
          end else begin
            baud_count <= baud_count + 16'd1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_count <= '0;
            if (!ready_reg) begin
              state     <= START;
              shift_reg <= hold_buf;
              ready_reg <= 1'b1;
            end else begin
              state    <= IDLE;
              busy_reg <= 1'b0;
            end
          end else begin
            baud_count <= baud_count + 16'd1;
          end
        end
        default: begin
          state      <= IDLE;
          busy_reg   <= 1'b0;
          baud_count <= '0;
        end
      endcase

      // A write can only land while the buffer is empty, which never
      // coincides with the buffer draining into the shift register above.
      if (bus.tx_en && ready_reg) begin
        hold_buf  <= bus.tx_data;
        ready_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_transmitter_serial.sv
// tb_transmitter_serial: three transmitters (DIVISOR 1, 2, 4) share one write
// port; each is checked every cycle against a frame-timeline model, plus
// directed scenarios with hand-computed expectations and a line decoder.
module tb_transmitter_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_en;
  logic [7:0] tx_data;

  always #5 clk = ~clk;

  transmitter_serial_if if1 ();
  transmitter_serial_if if2 ();
  transmitter_serial_if if4 ();

  assign if1.tx_en = tx_en;  assign if1.tx_data = tx_data;
  assign if2.tx_en = tx_en;  assign if2.tx_data = tx_data;
  assign if4.tx_en = tx_en;  assign if4.tx_data = tx_data;

  transmitter_serial #(.DIVISOR(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  transmitter_serial #(.DIVISOR(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  transmitter_serial #(.DIVISOR(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  logic [2:0] act_txd, act_rdy, act_busy;
  assign act_txd  = {if4.txd,      if2.txd,      if1.txd};
  assign act_rdy  = {if4.tx_ready, if2.tx_ready, if1.tx_ready};
  assign act_busy = {if4.tx_busy,  if2.tx_busy,  if1.tx_busy};

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int div_of(input int i);
    case (i)
      0:       return 1;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  // Line level for bit slot idx of an 8N1 frame carrying d.
  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    return 1'b1;
  endfunction

  // Model: a frame is a timeline of 10*DIVISOR cycles starting when the
  // buffered byte is taken; the line shows that timeline one cycle later.
  bit         m_buf_v [3];
  logic [7:0] m_buf_d [3];
  bit         m_act   [3];
  logic [7:0] m_dat   [3];
  int         m_pos   [3];
  logic       m_txd   [3];
  logic       m_rdy   [3];
  logic       m_busy  [3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_buf_v[i] = 1'b0; m_act[i] = 1'b0; m_pos[i] = 0;
        m_txd[i] = 1'b1; m_rdy[i] = 1'b1; m_busy[i] = 1'b0;
      end else begin
        bit accept;
        accept = tx_en && m_rdy[i];
        m_txd[i] = m_act[i] ? frame_bit(m_dat[i], m_pos[i] / div_of(i)) : 1'b1;
        if (m_act[i]) begin
          m_pos[i]++;
          if (m_pos[i] == 10 * div_of(i)) m_act[i] = 1'b0;
        end
        if (!m_act[i] && m_buf_v[i]) begin
          m_act[i] = 1'b1; m_pos[i] = 0; m_dat[i] = m_buf_d[i]; m_buf_v[i] = 1'b0;
        end
        if (accept) begin
          m_buf_v[i] = 1'b1; m_buf_d[i] = tx_data;
        end
        m_rdy[i]  = !m_buf_v[i];
        m_busy[i] = m_act[i];
      end
    end
  end

  // Compare every DUT output against the model on every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput($sformatf("txd_div%0d", div_of(i)),      64'(act_txd[i]),  64'(m_txd[i]));
        checkOutput($sformatf("tx_ready_div%0d", div_of(i)), 64'(act_rdy[i]),  64'(m_rdy[i]));
        checkOutput($sformatf("tx_busy_div%0d", div_of(i)),  64'(act_busy[i]), 64'(m_busy[i]));
      end
    end
  end

  // Recorder of per-cycle outputs for the directed scenarios.
  bit         rec_on = 1'b0;
  logic [2:0] r_txd [$];
  logic [2:0] r_rdy [$];
  logic [2:0] r_busy [$];

  always @(negedge clk) begin
    if (rec_on) begin
      r_txd.push_back(act_txd);
      r_rdy.push_back(act_rdy);
      r_busy.push_back(act_busy);
    end
  end

  // Downstream receiver for the DIVISOR=1 line: one sample per clk.
  int         dec_cnt = -1;
  logic [7:0] dec_sh;
  logic [7:0] dec_q [$];

  always @(negedge clk) begin
    if (dec_cnt < 0) begin
      if (act_txd[0] == 1'b0) dec_cnt = 0;
    end else if (dec_cnt < 8) begin
      dec_sh[dec_cnt] = act_txd[0];
      dec_cnt++;
    end else begin
      if (act_txd[0] == 1'b1) dec_q.push_back(dec_sh);
      dec_cnt = -1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [7:0] d, input int cycles);
    tx_en   = en;
    tx_data = d;
    repeat (cycles) tick();
  endtask

  task automatic clearRecord();
    r_txd.delete(); r_rdy.delete(); r_busy.delete();
  endtask

  initial begin
    logic [10:0] got11;
    logic [39:0] got40, exp40;
    logic [0:9]  fr3c;
    logic [7:0]  lb [3];
    int          cnt [3];
    int          zeros;
    int          n;

    // Reset with a write strobe held high: the strobe must be ignored.
    rst = 1'b1;
    applyStimulus(1'b1, 8'hC3, 3);
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("reset_txd_div%0d", div_of(i)),   64'(act_txd[i]),  64'd1);
      checkOutput($sformatf("reset_ready_div%0d", div_of(i)), 64'(act_rdy[i]),  64'd1);
      checkOutput($sformatf("reset_busy_div%0d", div_of(i)),  64'(act_busy[i]), 64'd0);
    end
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 3);

    // 0xA5 from idle: line sequence, start-bit latency and busy length.
    clearRecord();
    applyStimulus(1'b1, 8'hA5, 1);
    tx_en = 1'b0;
    rec_on = 1'b1;
    repeat (50) tick();
    rec_on = 1'b0;
    got11 = '0;
    for (int k = 1; k <= 11; k++) got11 = {got11[9:0], r_txd[k][0]};
    checkOutput("a5_line_sequence", 64'(got11), 64'(11'b101_0100_1011));
    checkOutput("a5_line_idle_after", 64'(r_txd[12][0]), 64'd1);
    cnt = '{0, 0, 0};
    foreach (r_busy[k]) for (int i = 0; i < 3; i++) cnt[i] += int'(r_busy[k][i]);
    checkOutput("a5_busy_cycles_div1", 64'(cnt[0]), 64'd10);
    checkOutput("a5_busy_cycles_div2", 64'(cnt[1]), 64'd20);
    checkOutput("a5_busy_cycles_div4", 64'(cnt[2]), 64'd40);
    checkOutput("a5_ready_low_after_accept", 64'(r_rdy[0][2]), 64'd0);
    checkOutput("a5_ready_back_next_cycle", 64'(r_rdy[1][2]), 64'd1);

    // 0x3C at DIVISOR=4: each bit held four cycles.
    clearRecord();
    applyStimulus(1'b1, 8'h3C, 1);
    tx_en = 1'b0;
    rec_on = 1'b1;
    repeat (50) tick();
    rec_on = 1'b0;
    fr3c = 10'b0001111001;
    got40 = '0; exp40 = '0;
    for (int j = 0; j < 40; j++) begin
      got40 = {got40[38:0], r_txd[j+2][2]};
      exp40 = {exp40[38:0], fr3c[j/4]};
    end
    checkOutput("3c_div4_line", 64'(got40), 64'(exp40));
    checkOutput("3c_div4_idle_before", 64'(r_txd[1][2]), 64'd1);
    checkOutput("3c_div4_idle_after", 64'(r_txd[42][2]), 64'd1);
    checkOutput("3c_div4_ready_back", 64'(r_rdy[1][2]), 64'd1);
    cnt[2] = 0;
    foreach (r_busy[k]) cnt[2] += int'(r_busy[k][2]);
    checkOutput("3c_div4_frame_cycles", 64'(cnt[2]), 64'd40);

    // Back-to-back 0x01 then 0xFF: no idle gap between frames.
    clearRecord();
    applyStimulus(1'b1, 8'h01, 1);
    tx_en = 1'b0;
    rec_on = 1'b1;
    applyStimulus(1'b0, 8'h00, 3);
    applyStimulus(1'b1, 8'hFF, 1);
    applyStimulus(1'b0, 8'h00, 100);
    rec_on = 1'b0;
    cnt = '{0, 0, 0};
    foreach (r_busy[k]) for (int i = 0; i < 3; i++) cnt[i] += int'(r_busy[k][i]);
    checkOutput("b2b_div2_busy_total", 64'(cnt[1]), 64'd40);
    checkOutput("b2b_div2_busy_first", 64'(r_busy[1][1]), 64'd1);
    checkOutput("b2b_div2_busy_last", 64'(r_busy[40][1]), 64'd1);
    checkOutput("b2b_div2_busy_end", 64'(r_busy[41][1]), 64'd0);
    checkOutput("b2b_div2_stop_bit", 64'(r_txd[21][1]), 64'd1);
    checkOutput("b2b_div2_next_start", 64'(r_txd[22][1]), 64'd0);
    checkOutput("b2b_div4_busy_total", 64'(cnt[2]), 64'd80);

    // tx_en held high over 0x11, 0x22, 0x33: the third write is rejected.
    dec_q.delete(); dec_cnt = -1;
    applyStimulus(1'b1, 8'h11, 2);
    applyStimulus(1'b1, 8'h22, 1);
    applyStimulus(1'b1, 8'h33, 4);
    applyStimulus(1'b0, 8'h00, 100);
    checkOutput("held_en_byte_count", 64'(dec_q.size()), 64'd2);
    if (dec_q.size() == 2) begin
      checkOutput("held_en_byte0", 64'(dec_q[0]), 64'h11);
      checkOutput("held_en_byte1", 64'(dec_q[1]), 64'h22);
    end

    // Loopback into the receiver: 0x5A, 0x00, 0xFF in order.
    dec_q.delete(); dec_cnt = -1;
    lb = '{8'h5A, 8'h00, 8'hFF};
    for (int b = 0; b < 3; b++) begin
      n = 0;
      while (!if1.tx_ready && n < 50) begin
        tick();
        n++;
      end
      if (n == 50) checkOutput("loopback_ready_timeout", 64'd0, 64'd1);
      applyStimulus(1'b1, lb[b], 1);
      tx_en = 1'b0;
    end
    applyStimulus(1'b0, 8'h00, 150);
    checkOutput("loopback_byte_count", 64'(dec_q.size()), 64'd3);
    if (dec_q.size() == 3) begin
      for (int b = 0; b < 3; b++)
        checkOutput($sformatf("loopback_byte%0d", b), 64'(dec_q[b]), 64'(lb[b]));
    end

    // Reset during data bit 3 of 0x55 (DIVISOR=4) with 0xAA buffered.
    applyStimulus(1'b1, 8'h55, 1);
    applyStimulus(1'b0, 8'h00, 1);
    applyStimulus(1'b1, 8'hAA, 1);
    applyStimulus(1'b0, 8'h00, 16);
    checkOutput("midreset_div4_busy_before", 64'(if4.tx_busy), 64'd1);
    checkOutput("midreset_div4_ready_before", 64'(if4.tx_ready), 64'd0);
    rst = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("midreset_txd_div%0d", div_of(i)),   64'(act_txd[i]),  64'd1);
      checkOutput($sformatf("midreset_ready_div%0d", div_of(i)), 64'(act_rdy[i]),  64'd1);
      checkOutput($sformatf("midreset_busy_div%0d", div_of(i)),  64'(act_busy[i]), 64'd0);
    end
    rst = 1'b0;
    clearRecord();
    rec_on = 1'b1;
    repeat (60) tick();
    rec_on = 1'b0;
    zeros = 0;
    foreach (r_txd[k]) for (int i = 0; i < 3; i++) zeros += int'(!r_txd[k][i]) + int'(r_busy[k][i]);
    checkOutput("midreset_buffer_discarded", 64'(zeros), 64'd0);

    // Random writes with occasional resets, checked by the model every cycle.
    for (int c = 0; c < 2000; c++) begin
      rst     = ($urandom_range(0, 299) == 0);
      tx_en   = ($urandom_range(0, 3) == 0);
      tx_data = 8'($urandom);
      tick();
    end
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 150);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
